// File: rtl/maze_pkg.sv
// Shared packet layout and constants for the maze torus network.
// Field offsets describe the 23-bit packet carried between nodes.
package maze_pkg;

    localparam int PKT_W     = 23;
    localparam int GRID_SIZE = 8;

    localparam int TYPE_MSB = 22;
    localparam int TYPE_LSB = 21;
    localparam int QOS_BIT  = 20;
    localparam int SRC_MSB  = 19;
    localparam int SRC_LSB  = 14;
    localparam int TGT_MSB  = 13;
    localparam int TGT_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef logic [PKT_W-1:0] pkt_t;

    function automatic logic pkt_qos(pkt_t p);
        return p[QOS_BIT];
    endfunction

endpackage

// File: rtl/maze_rr_arb.sv
// Rotating-priority arbiter: first requester at or after ptr wins.
// Purely combinational; the caller owns the pointer register.
module maze_rr_arb #(
    parameter int N  = 7,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/maze_xin_arb.sv
// X-direction ingress arbiter: QoS-first round-robin with aging,
// winner delivered through a 2-entry output buffer.
module maze_xin_arb #(
    parameter int N_IN    = 7,
    parameter int PKT_W   = 23,
    parameter int AGE_MAX = 15,
    parameter int AGE_W   = 4,
    parameter int PORT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN-1:0]       in_vld,
    output logic [N_IN-1:0]       in_rdy,
    input  logic [N_IN*PKT_W-1:0] in_pkt,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [PKT_W-1:0]      out_pkt,
    output logic [PORT_W-1:0]     out_port,
    output logic                  out_aged
);

    import maze_pkg::*;

    logic [N_IN-1:0]   qos;
    logic [N_IN-1:0]   hi;
    logic [N_IN-1:0]   req;
    logic [N_IN-1:0]   grant;
    logic [AGE_W-1:0]  age [N_IN];
    logic [PORT_W-1:0] ptr;
    logic [PORT_W-1:0] g_idx;
    logic [PKT_W-1:0]  win_pkt;
    logic              win_aged;
    logic [1:0]        count;
    logic              acc;
    logic              xfer;
    logic              push;
    logic              pop;

    logic [PKT_W-1:0]  pkt0;
    logic [PKT_W-1:0]  pkt1;
    logic [PORT_W-1:0] port0;
    logic [PORT_W-1:0] port1;
    logic              aged0;
    logic              aged1;

    always_comb begin
        qos = '0;
        hi  = '0;
        for (int i = 0; i < N_IN; i++) begin
            qos[i] = in_pkt[i*PKT_W + QOS_BIT];
            hi[i]  = in_vld[i]
                   & (qos[i] | (age[i] == AGE_W'(AGE_MAX)));
        end
        req = (|hi) ? hi : in_vld;
    end

    maze_rr_arb #(
        .N  (N_IN),
        .PW (PORT_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    // Acceptance depends only on registered occupancy, never on out_rdy.
    assign acc    = ~rst & (count != 2'd2);
    assign in_rdy = acc ? grant : '0;
    assign xfer   = |in_rdy;
    assign push   = xfer;
    assign pop    = out_vld & out_rdy;

    always_comb begin
        g_idx   = '0;
        win_pkt = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                g_idx   = PORT_W'(i);
                win_pkt = in_pkt[i*PKT_W +: PKT_W];
            end
        end
        win_aged = (|hi) & ~qos[g_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < N_IN; i++) begin
                age[i] <= '0;
            end
        end else if (xfer) begin
            if (g_idx == PORT_W'(N_IN-1)) begin
                ptr <= '0;
            end else begin
                ptr <= g_idx + 1'b1;
            end
            for (int i = 0; i < N_IN; i++) begin
                if (in_rdy[i]) begin
                    age[i] <= '0;
                end else if (in_vld[i] && !qos[i]
                             && age[i] < AGE_W'(AGE_MAX)) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    // Entry 0 is always the head; entry 1 shifts down on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            pkt0  <= '0;
            port0 <= '0;
            aged0 <= 1'b0;
            pkt1  <= '0;
            port1 <= '0;
            aged1 <= 1'b0;
        end else begin
            unique case (1'b1)
                (push && !pop): begin
                    if (count == 2'd0) begin
                        pkt0  <= win_pkt;
                        port0 <= g_idx;
                        aged0 <= win_aged;
                    end else begin
                        pkt1  <= win_pkt;
                        port1 <= g_idx;
                        aged1 <= win_aged;
                    end
                    count <= count + 2'd1;
                end
                (!push && pop): begin
                    pkt0  <= pkt1;
                    port0 <= port1;
                    aged0 <= aged1;
                    count <= count - 2'd1;
                end
                (push && pop): begin
                    pkt0  <= win_pkt;
                    port0 <= g_idx;
                    aged0 <= win_aged;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_vld  = (count != 2'd0);
    assign out_pkt  = pkt0;
    assign out_port = port0;
    assign out_aged = aged0;

    a_rdy_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(in_rdy));

    a_rdy_vld: assert property (
        @(posedge clk) disable iff (rst) ((in_rdy & ~in_vld) == '0));

    a_out_stable: assert property (
        @(posedge clk) disable iff (rst)
        (out_vld && !out_rdy) |=> $stable(out_pkt));

endmodule

// File: tb/tb_maze_xin_arb.sv
// Directed bench for maze_xin_arb: reset, round-robin, QoS/aging,
// backpressure, pointer wrap and mid-flight reset.
module tb_maze_xin_arb;

    localparam int N = 7;
    localparam int W = 23;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_vld;
    logic [N-1:0]   in_rdy;
    logic [N*W-1:0] in_pkt;
    logic           out_vld;
    logic           out_rdy;
    logic [W-1:0]   out_pkt;
    logic [2:0]     out_port;
    logic           out_aged;

    int n_chk  = 0;
    int n_fail = 0;

    maze_xin_arb dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_pkt   (in_pkt),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_pkt  (out_pkt),
        .out_port (out_port),
        .out_aged (out_aged)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int ch, input logic q);
        logic [5:0] src;
        logic [7:0] dat;
        src = 6'(ch);
        dat = 8'(8'hA0 + ch);
        return {2'b01, q, src, 6'd9, dat};
    endfunction

    task automatic set_ch(input int ch, input logic q);
        in_pkt[ch*W +: W] = mk(ch, q);
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_vld  = '0;
        out_rdy = 1'b0;
        nclk();
        nclk();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        in_vld  = '0;
        out_rdy = 1'b0;
        in_pkt  = '0;
        for (int i = 0; i < N; i++) set_ch(i, 1'b0);

        // reset cycle, requests present
        in_vld = '1;
        #1;
        check("rst_in_rdy", in_rdy, 0);
        nclk();
        #1;
        check("rst_out_vld", out_vld, 0);
        check("rst_out_pkt", out_pkt, 0);
        check("rst_out_port", out_port, 0);
        in_vld = '0;
        nclk();
        rst = 1'b0;

        // idle
        for (int c = 0; c < 10; c++) begin
            #1;
            check("idle_in_rdy", in_rdy, 0);
            check("idle_out_vld", out_vld, 0);
            check("idle_ptr", dut.ptr, 0);
            nclk();
        end

        // all seven requesting, qos=0
        in_vld  = '1;
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_grant", in_rdy, 1 << (k % 7));
            if (k == 0) begin
                check("rr_lat0", out_vld, 0);
            end else begin
                check("rr_out_vld", out_vld, 1);
                check("rr_out_port", out_port, (k - 1) % 7);
                check("rr_out_pkt", out_pkt, mk((k - 1) % 7, 1'b0));
            end
            nclk();
        end
        in_vld = '0;
        #1;
        check("rr_last_port", out_port, 0);
        nclk();
        #1;
        check("rr_drain", out_vld, 0);

        // qos on channel 3, aging on 0 and 5
        do_reset();
        set_ch(3, 1'b1);
        in_vld  = 7'b0101001;
        out_rdy = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            check("qos_win", in_rdy, 8);
            if (c > 0) check("qos_aged0", out_aged, 0);
            nclk();
        end
        #1;
        check("age5_win", in_rdy, 1 << 5);
        check("age5_prev", out_port, 3);
        nclk();
        #1;
        check("age0_win", in_rdy, 1);
        check("age5_port", out_port, 5);
        check("age5_aged", out_aged, 1);
        nclk();
        #1;
        check("qos_back", in_rdy, 8);
        check("age0_port", out_port, 0);
        check("age0_aged", out_aged, 1);
        check("age0_clr", dut.age[0], 0);
        nclk();
        #1;
        check("qos3_port", out_port, 3);
        check("qos3_aged", out_aged, 0);
        in_vld = '0;
        set_ch(3, 1'b0);
        nclk();

        // backpressure
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 7'b1010110;
        #1;
        check("bp_g1", in_rdy, 2);
        nclk();
        #1;
        check("bp_g2", in_rdy, 4);
        check("bp_head1", out_port, 1);
        nclk();
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_full_rdy", in_rdy, 0);
            check("bp_full_vld", out_vld, 1);
            check("bp_full_port", out_port, 1);
            nclk();
        end
        check("bp_count", dut.count, 2);
        out_rdy = 1'b1;
        #1;
        check("bp_pop_rdy", in_rdy, 0);
        check("bp_pop_port", out_port, 1);
        nclk();
        #1;
        check("bp_resume", in_rdy, 1 << 4);
        check("bp_port2", out_port, 2);
        nclk();
        #1;
        check("bp_next", in_rdy, 1 << 6);
        check("bp_port4", out_port, 4);
        nclk();
        in_vld = '0;
        #1;
        check("bp_port6", out_port, 6);
        nclk();
        #1;
        check("bp_empty", out_vld, 0);

        // pointer wrap
        do_reset();
        out_rdy = 1'b1;
        in_vld  = 7'b0100000;
        #1;
        check("wrap_g5", in_rdy, 1 << 5);
        nclk();
        in_vld = 7'b1000100;
        #1;
        check("wrap_ptr6", dut.ptr, 6);
        check("wrap_g6", in_rdy, 1 << 6);
        nclk();
        #1;
        check("wrap_ptr0", dut.ptr, 0);
        check("wrap_g2", in_rdy, 4);
        nclk();
        in_vld = '0;
        nclk();

        // reset with packets buffered
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 7'b0000111;
        nclk();
        nclk();
        #1;
        check("mr_count", dut.count, 2);
        check("mr_age2", dut.age[2], 2);
        check("mr_ptr", dut.ptr, 2);
        rst = 1'b1;
        #1;
        check("mr_rdy", in_rdy, 0);
        nclk();
        #1;
        check("mr_out_vld", out_vld, 0);
        check("mr_count0", dut.count, 0);
        check("mr_ptr0", dut.ptr, 0);
        check("mr_age0", dut.age[2], 0);
        rst     = 1'b0;
        in_vld  = '0;
        out_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("mr_no_emit", out_vld, 0);
            nclk();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
